// File: rtl/cpu0_ocimem_ctrl.sv
// On-chip debug memory controller: a 256x32 RAM shared between JTAG debug
// requests (address register with auto-increment) and a CPU slave port.
module cpu0_ocimem_ctrl #(
  parameter logic [7:0] PROT_BASE = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [7:0]  cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [2:0] {IDLE, J_WR, J_RD, J_CAP, C_ACC, C_ACK} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  jaddr_reg;
  logic        jrd_pend_reg, jwr_pend_reg;
  logic [31:0] jwdata_reg;
  logic [31:0] mon_dreg_reg, cpu_readdata_reg;
  logic        monitor_ready_reg, monitor_error_reg;

  logic [31:0] mem [256];
  logic [31:0] ram_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;

  logic jaddr_inc, clr_wr, clr_rd, prot_err, jtag_cap, cpu_cap;
  logic wr_req, rd_req, rd_pulse;

  wire unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Pulses arriving this cycle count as pending so IDLE never lets a CPU
  // access slip in ahead of a JTAG request that arrives alongside it.
  assign rd_pulse = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[17]);
  assign wr_req   = jwr_pend_reg | take_action_ocimem_b;
  assign rd_req   = jrd_pend_reg | rd_pulse;

  always_comb begin
    state_next = state_reg;
    ram_addr   = jaddr_reg;
    ram_wdata  = jwdata_reg;
    ram_we     = 1'b0;
    jaddr_inc  = 1'b0;
    clr_wr     = 1'b0;
    clr_rd     = 1'b0;
    prot_err   = 1'b0;
    jtag_cap   = 1'b0;
    cpu_cap    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_req)                     state_next = J_WR;
        else if (rd_req)                state_next = J_RD;
        else if (cpu_read || cpu_write) state_next = C_ACC;
      end
      J_WR: begin
        if (jaddr_reg >= PROT_BASE) prot_err = 1'b1;
        else                        ram_we   = 1'b1;
        clr_wr     = 1'b1;
        jaddr_inc  = 1'b1;
        state_next = IDLE;
      end
      J_RD: begin
        clr_rd     = 1'b1;
        state_next = J_CAP;
      end
      J_CAP: begin
        jtag_cap   = 1'b1;
        jaddr_inc  = 1'b1;
        state_next = IDLE;
      end
      C_ACC: begin
        ram_addr   = cpu_address;
        ram_wdata  = cpu_writedata;
        ram_we     = cpu_write;
        state_next = C_ACK;
      end
      C_ACK: begin
        cpu_cap    = cpu_read;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      jaddr_reg         <= 8'h00;
      jrd_pend_reg      <= 1'b0;
      jwr_pend_reg      <= 1'b0;
      jwdata_reg        <= 32'h0;
      mon_dreg_reg      <= 32'h0;
      monitor_ready_reg <= 1'b0;
      monitor_error_reg <= 1'b0;
      cpu_readdata_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      // A fresh address load overrides any increment in the same cycle.
      if (take_action_ocimem_a)  jaddr_reg <= jdo[25:18];
      else if (jaddr_inc)        jaddr_reg <= jaddr_reg + 8'd1;
      jwr_pend_reg <= take_action_ocimem_b | (jwr_pend_reg & ~clr_wr);
      jrd_pend_reg <= rd_pulse | (jrd_pend_reg & ~clr_rd);
      if (take_action_ocimem_b) jwdata_reg <= jdo[34:3];
      if (take_action_ocimem_a) begin
        monitor_ready_reg <= 1'b0;
        monitor_error_reg <= 1'b0;
      end else begin
        if (jtag_cap) monitor_ready_reg <= 1'b1;
        if (prot_err) monitor_error_reg <= 1'b1;
      end
      if (jtag_cap) mon_dreg_reg     <= ram_rdata;
      if (cpu_cap)  cpu_readdata_reg <= ram_rdata;
    end
  end

  // RAM contents survive reset; only the write strobe is blocked by it.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  assign cpu_waitrequest = (state_reg != C_ACK);
  assign cpu_readdata    = cpu_readdata_reg;
  assign MonDReg         = mon_dreg_reg;
  assign monitor_ready   = monitor_ready_reg;
  assign monitor_error   = monitor_error_reg;

endmodule

// File: tb/tb_cpu0_ocimem_ctrl.sv
// Randomized bench for cpu0_ocimem_ctrl against a transaction-level model
// of the debug RAM, JTAG address register and monitor flags.
module tb_cpu0_ocimem_ctrl;
  localparam logic [7:0] PROT_BASE = 8'hF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  cpu0_ocimem_ctrl #(.PROT_BASE(PROT_BASE)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m [256];
  logic [7:0]  m_jaddr;
  logic [31:0] m_mon;
  logic        m_rdy, m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] rand_jdo();
    return {6'($urandom), $urandom};
  endfunction

  task automatic jtag_settle(input string tag);
    repeat (4) tick();
    chk({tag, "_mon"}, MonDReg, m_mon);
    chk({tag, "_rdy"}, 32'(monitor_ready), 32'(m_rdy));
    chk({tag, "_err"}, 32'(monitor_error), 32'(m_err));
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = rand_jdo();
    j[25:18] = a;
    j[17] = rd;
    jdo = j;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    m_jaddr = a; m_rdy = 1'b0; m_err = 1'b0;
    if (rd) begin
      m_mon = mem_m[m_jaddr]; m_rdy = 1'b1; m_jaddr++;
    end
    jtag_settle("jtag_a");
  endtask

  task automatic jtag_b(input logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    jdo = j;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    if (m_jaddr >= PROT_BASE) m_err = 1'b1;
    else                      mem_m[m_jaddr] = d;
    m_jaddr++;
    jtag_settle("jtag_b");
  endtask

  task automatic jtag_r();
    jdo = rand_jdo();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    m_mon = mem_m[m_jaddr]; m_rdy = 1'b1; m_jaddr++;
    jtag_settle("jtag_r");
  endtask

  // Counts falling edges until waitrequest is seen low, bounded.
  task automatic cpu_wait(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (!cpu_waitrequest) begin ok = 1'b1; break; end
    end
    chk("cpu_ack", 32'(ok), 32'd1);
  endtask

  task automatic cpu_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input int exp_lat);
    int n; bit ok;
    cpu_address = a; cpu_write = wr; cpu_read = ~wr; cpu_writedata = d;
    cpu_wait(n, ok);
    if (exp_lat > 0) chk("cpu_lat", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (wr) mem_m[a] = d;
    else    chk("cpu_rdata", cpu_readdata, mem_m[a]);
  endtask

  initial begin
    logic [37:0] j;
    logic [31:0] d1, d2;
    int n; bit ok;

    reset = 1'b1; jdo = '0;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    cpu_address = 0; cpu_read = 0; cpu_write = 0; cpu_writedata = 0;
    m_jaddr = 0; m_mon = 0; m_rdy = 0; m_err = 0;
    repeat (3) tick();
    chk("rst_wait", 32'(cpu_waitrequest), 32'd1);
    chk("rst_mon", MonDReg, 32'h0);
    chk("rst_rdy", 32'(monitor_ready), 32'd0);
    chk("rst_err", 32'(monitor_error), 32'd0);
    chk("rst_rdata", cpu_readdata, 32'h0);

    // Pulses coincident with reset must be dropped.
    jdo = rand_jdo();
    take_action_ocimem_b = 1'b1; take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_pulse_rdy", 32'(monitor_ready), 32'd0);
    chk("rst_pulse_wait", 32'(cpu_waitrequest), 32'd1);

    for (int i = 0; i < 256; i++) cpu_xfer(1'b1, 8'(i), $urandom, (i == 0) ? 3 : 0);

    jtag_a(8'h10, 1'b0);
    jtag_b(32'hDEADBEEF);
    cpu_xfer(1'b0, 8'h10, 32'h0, 3);
    jtag_a(8'h10, 1'b1);
    jtag_r();
    jtag_a(8'hF0, 1'b0);
    jtag_b(32'h1);
    cpu_xfer(1'b0, 8'hF0, 32'h0, 3);
    jtag_r();
    jtag_a(8'h20, 1'b0);
    jtag_a(8'hFF, 1'b1);
    jtag_r();

    // CPU read raised together with a JTAG write: write goes first.
    jtag_a(8'h10, 1'b0);
    d1 = 32'hC0FFEE11;
    j = rand_jdo(); j[34:3] = d1; jdo = j;
    cpu_address = 8'h10; cpu_read = 1'b1; cpu_write = 1'b0;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    mem_m[8'h10] = d1; m_jaddr = 8'h11;
    cpu_wait(n, ok);
    chk("jfirst_lat", 32'(n), 32'd4);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    chk("jfirst_rdata", cpu_readdata, d1);
    jtag_r();

    // Two write pulses during a CPU access: only the last is written, once.
    jtag_a(8'h40, 1'b0);
    d1 = $urandom; d2 = $urandom;
    cpu_address = 8'h80; cpu_read = 1'b1;
    tick();
    j = rand_jdo(); j[34:3] = d1; jdo = j; take_action_ocimem_b = 1'b1;
    tick();
    j = rand_jdo(); j[34:3] = d2; jdo = j;
    tick();
    take_action_ocimem_b = 1'b0; cpu_read = 1'b0;
    chk("lastwin_rdata", cpu_readdata, mem_m[8'h80]);
    mem_m[8'h40] = d2; m_jaddr = 8'h41;
    repeat (4) tick();
    jtag_r();
    jtag_a(8'h40, 1'b1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: cpu_xfer(1'b0, 8'($urandom), 32'h0, 3);
        1: cpu_xfer(1'b1, 8'($urandom), $urandom, 3);
        2: jtag_a($urandom_range(0, 1) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom),
                  1'($urandom));
        3: jtag_b($urandom);
        default: jtag_r();
      endcase
    end

    // Reset while a CPU write sits in C_ACC: the write must not land.
    d1 = ~mem_m[8'h33];
    cpu_address = 8'h33; cpu_write = 1'b1; cpu_writedata = d1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; cpu_write = 1'b0;
    m_jaddr = 0; m_mon = 0; m_rdy = 0; m_err = 0;
    chk("rst_acc_wait", 32'(cpu_waitrequest), 32'd1);
    chk("rst_acc_mon", MonDReg, 32'h0);
    chk("rst_acc_rdy", 32'(monitor_ready), 32'd0);
    chk("rst_acc_rdata", cpu_readdata, 32'h0);
    tick();
    cpu_xfer(1'b0, 8'h33, 32'h0, 3);
    jtag_r();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cpu0_ocimem_ctrl.md
CPU0_OCIMEM_CTRL -- requirements
Module: cpu0_ocimem_ctrl

Interface
REQ-001 SHALL have parameter PROT_BASE, default 8'hF0: lowest word address write-protected against JTAG writes.
REQ-002 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port jdo  in  38  JTAG data word from the debug sysclk stage.
REQ-005 SHALL have port take_action_ocimem_a  in  1  one-cycle pulse: load address / read flag.
REQ-006 SHALL have port take_action_ocimem_b  in  1  one-cycle pulse: JTAG write request.
REQ-007 SHALL have port take_no_action_ocimem_a  in  1  one-cycle pulse: JTAG read request.
REQ-008 SHALL have ports cpu_address  in  8, cpu_read  in  1, cpu_write  in  1, cpu_writedata  in  32: CPU slave request.
REQ-009 SHALL have ports cpu_readdata  out  32, cpu_waitrequest  out  1: CPU slave response.
REQ-010 SHALL have ports MonDReg  out  32, monitor_ready  out  1, monitor_error  out  1: results back to the debug tck stage.

Function
REQ-011 SHALL contain a 256x32 synchronous RAM, one-cycle read latency, shared by JTAG and CPU.
REQ-012 SHALL hold an 8-bit JTAG address register jaddr; increments wrap 8'hFF -> 8'h00.
REQ-013 take_action_ocimem_a SHALL load jaddr <= jdo[25:18], clear monitor_ready and monitor_error; if jdo[17]=1 also set jrd_pend.
REQ-014 take_no_action_ocimem_a SHALL set jrd_pend; take_action_ocimem_b SHALL set jwr_pend and latch jwdata <= jdo[34:3].
REQ-015 A second ocimem_b pulse before service SHALL overwrite jwdata (last wins); one write only.
REQ-016 ocimem_a in the same cycle as a state-machine increment of jaddr SHALL win (loaded value, no increment).
REQ-017 FSM states: IDLE, J_WR, J_RD, J_CAP, C_ACC, C_ACK.
REQ-018 IDLE priority: jwr_pend -> J_WR; else jrd_pend -> J_RD; else cpu_read|cpu_write -> C_ACC; else stay.
REQ-019 J_WR (1 cycle): write jwdata at jaddr unless jaddr >= PROT_BASE (write suppressed, monitor_error <= 1); clear jwr_pend; jaddr++; -> IDLE.
REQ-020 J_RD: present jaddr to RAM; clear jrd_pend; -> J_CAP.
REQ-021 J_CAP: MonDReg <= RAM data, monitor_ready <= 1, jaddr++; -> IDLE.
REQ-022 C_ACC: present cpu_address; if cpu_write, write cpu_writedata (no protection for CPU); -> C_ACK.
REQ-023 C_ACK: cpu_readdata <= RAM data on read, held until next CPU read; -> IDLE.
REQ-024 cpu_waitrequest SHALL be 0 only in C_ACK; CPU holds request stable until then; min CPU latency 2 cycles from IDLE.
REQ-025 JTAG requests arriving during a CPU access SHALL wait until the CPU access reaches C_ACK; never abort a CPU transfer.
REQ-026 Back-to-back JTAG requests SHALL starve CPU; no fairness required.
REQ-027 monitor_ready and monitor_error SHALL be sticky until next ocimem_a or reset.
REQ-028 jdo bits not named above SHALL be ignored.

Reset
REQ-029 On reset: state IDLE, jaddr 0, jrd_pend 0, jwr_pend 0, jwdata 0, MonDReg 0, monitor_ready 0, monitor_error 0, cpu_readdata 0, cpu_waitrequest 1.
REQ-030 Reset mid-operation SHALL abandon any access in flight; RAM contents not cleared; a write in the reset cycle SHALL NOT occur.
REQ-031 Request pulses coincident with reset SHALL be discarded.

Verification
REQ-032 Load addr 8'h10 (ocimem_a, jdo[17]=0), ocimem_b with data 32'hDEADBEEF -> RAM[0x10]=DEADBEEF, jaddr=0x11, monitor_error 0.
REQ-033 ocimem_a addr 0x10 with jdo[17]=1 -> after 2 cycles in J_RD/J_CAP, MonDReg=DEADBEEF, monitor_ready=1, jaddr=0x11.
REQ-034 ocimem_a addr 0xF0, ocimem_b data 32'h1 -> RAM[0xF0] unchanged, monitor_error=1, jaddr=0xF1; next ocimem_a clears it.
REQ-035 jaddr 0xFF, read -> MonDReg=RAM[0xFF], jaddr wraps to 0x00.
REQ-036 cpu_read addr 0x10 asserted same cycle as ocimem_b pulse -> J_WR first, then CPU sees waitrequest low in C_ACK with the newly written value.
REQ-037 Assert reset while in C_ACC with cpu_write -> no RAM write, state IDLE, cpu_waitrequest 1 next cycle.
